leve_irf_sched: RTL

Issue scheduler and write-port arbiter for the LEVE integer register file. It keeps a one-bit-per-register pending-write scoreboard and stalls issue on RAW/WAW hazards. It also merges the ALU and LSU writeback streams onto the single IRF write port. It sits between decode/issue and the IRF, driving the IRF read-enable and write-port inputs.

---
 rtl/leve_irf_sched.sv | 117 +++++++++++
 1 files changed

// File: rtl/leve_irf_sched.sv
// Issue scheduler and IRF write-port arbiter: pending-write scoreboard, RAW/WAW stall,
// ALU-priority writeback merge. Macro LEVE_IRF_SCHED_STARVE_EN enables LSU starvation throttle.
`ifndef XLEN
`define XLEN 32
`endif

module leve_irf_sched #(
  parameter int NUM_REG    = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               ISSUE_VALID,
  output logic               ISSUE_READY,
  input  logic               ISSUE_RS1_USE,
  input  logic               ISSUE_RS2_USE,
  input  logic [4:0]         ISSUE_RS1,
  input  logic [4:0]         ISSUE_RS2,
  input  logic               ISSUE_RD_USE,
  input  logic [4:0]         ISSUE_RD,
  output logic               RS1_VALID,
  output logic               RS2_VALID,
  input  logic               ALU_WB_VALID,
  input  logic [4:0]         ALU_WB_RD,
  input  logic [`XLEN-1:0]   ALU_WB_DATA,
  input  logic               LSU_WB_VALID,
  output logic               LSU_WB_READY,
  input  logic [4:0]         LSU_WB_RD,
  input  logic [`XLEN-1:0]   LSU_WB_DATA,
  output logic               RD_WE,
  output logic [4:0]         RD,
  output logic [`XLEN-1:0]   WB_DATA,
  output logic [NUM_REG-1:0] PENDING
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  // Handshakes: issue fires on ISSUE_VALID & ISSUE_READY; LSU writeback is
  // accepted on LSU_WB_VALID & LSU_WB_READY; ALU writeback is always taken.
  logic [NUM_REG-1:0] sb;
  logic               hazard;
  logic               throttle;
  logic               fire;
  logic [NUM_REG-1:0] set_vec;
  logic [NUM_REG-1:0] clr_vec;

  assign hazard = (ISSUE_RS1_USE & sb[ISSUE_RS1]) |
                  (ISSUE_RS2_USE & sb[ISSUE_RS2]) |
                  (ISSUE_RD_USE  & sb[ISSUE_RD]);

  assign ISSUE_READY  = ~hazard & ~throttle;
  assign fire         = ISSUE_VALID & ISSUE_READY;
  assign RS1_VALID    = ISSUE_RS1_USE & fire;
  assign RS2_VALID    = ISSUE_RS2_USE & fire;
  assign LSU_WB_READY = ~ALU_WB_VALID;
  assign PENDING      = sb;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (fire && ISSUE_RD_USE && ISSUE_RD != 5'd0)
      set_vec = NUM_REG'(1) << ISSUE_RD;
    if (RD_WE)
      clr_vec = NUM_REG'(1) << RD;
  end

  // Set is OR-ed after the clear so a same-cycle set wins; bit 0 never latches.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sb <= '0;
    end else begin
      sb <= ((sb & ~clr_vec) | set_vec) & ~NUM_REG'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      RD_WE   <= 1'b0;
      RD      <= 5'd0;
      WB_DATA <= '0;
    end else if (ALU_WB_VALID) begin
      RD_WE   <= 1'b1;
      RD      <= ALU_WB_RD;
      WB_DATA <= ALU_WB_DATA;
    end else if (LSU_WB_VALID) begin
      RD_WE   <= 1'b1;
      RD      <= LSU_WB_RD;
      WB_DATA <= LSU_WB_DATA;
    end else begin
      RD_WE   <= 1'b0;
    end
  end

`ifdef LEVE_IRF_SCHED_STARVE_EN
  logic [CW-1:0] starve_cnt;

  // Counts consecutive cycles the LSU is refused; saturates so throttle holds.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      starve_cnt <= '0;
    end else if (LSU_WB_VALID && !LSU_WB_READY) begin
      if (starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  assign throttle = (starve_cnt == SMAX);
`else
  logic [CW-1:0] unused_starve_max;
  assign unused_starve_max = SMAX;
  assign throttle = 1'b0;
`endif

endmodule
